load_store_unit: RTL and testbench
==================================

# load_store_unit

Sub-word load/store unit between the datapath (ALU result, RD2, funct3) and the word-only data memory. It converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned memory accesses. Byte and halfword stores use a read-modify-write sequence because the memory only writes full words. It also flags misaligned or illegal accesses, and stalls the core through a busy/done handshake.

## Interface
Parameters:
- none. Data and address are fixed at 32 bits; little-endian.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; sampled only when busy=0
- we  in  1  1=store, 0=load; sampled with req
- funct3  in  3  RV32I width code; sampled with req
- addr  in  32  byte address (ALUResult); sampled with req
- wdata  in  32  store data (RD2), right-justified; sampled with req
- rdata  out  32  extended load result; holds until the next successful load
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse, registered
- err  out  1  misaligned/illegal flag; valid only while done=1
- mem_we  out  1  memory write enable (WE)
- mem_addr  out  32  word address {addr_q[31:2],2'b00} (A)
- mem_wd  out  32  memory write data (WD)
- mem_rd  in  32  memory read data (RD); combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, MERGE.
- **IDLE**
  - If req=1, latch we, funct3, addr and wdata into *_q registers, then go to ACCESS.
  - req=0 stays in IDLE.
- **ACCESS**
  - err condition is any one of:
    - funct3 not in {000,001,010,100,101}
    - store with funct3 in {100,101}
    - halfword with addr_q[0]=1
    - word with addr_q[1:0]!=0
  - On err: mem_we=0, rdata unchanged, done=1 and err=1 next cycle, go to IDLE.
  - Load: select the byte by addr_q[1:0] or the halfword by addr_q[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
    - rdata <= result, done=1, go to IDLE.
  - SW: mem_we=1, mem_wd=wdata_q, done=1, go to IDLE.
  - SB/SH: old_q <= mem_rd, go to MERGE.
- **MERGE**
  - mem_we=1.
  - mem_wd = old_q with the byte lane addr_q[1:0] (SB) or halfword lane addr_q[1] (SH) replaced by wdata_q[7:0] or wdata_q[15:0].
  - done=1, go to IDLE.
- mem_we is combinational from state and is forced to 0 whenever rst=1.
- mem_wd is 0 when mem_we=0.
- mem_addr = {addr_q[31:2],2'b00} in all states.
- req while busy=1 is ignored; no queuing.
- A back-to-back req is accepted in the same cycle that done=1.

## Timing
- Reset values: state=IDLE, rdata=0, done=0, err=0, busy=0, mem_we=0, all *_q=0.
- Cycle 0 is the IDLE cycle in which req=1 is sampled.
  - ACCESS occupies cycle 1.
  - Load, SW and err: done=1 in cycle 2.
  - SB/SH: MERGE in cycle 2, done=1 in cycle 3.
- Memory write commits at the posedge ending the cycle with mem_we=1.
  - Exactly one mem_we cycle per store; zero for loads and err.
- rdata updates at the same edge that raises done.
- Reset mid-operation (ACCESS or MERGE):
  - no write in the reset cycle;
  - next cycle is IDLE with done=0 and err=0;
  - rdata=0 and memory unchanged.
- Throughput: one access every 2 cycles (load/SW) or every 3 cycles (SB/SH).

## Test plan
Preload word 0x10 = 0x8899AABB unless stated otherwise.

- **Byte loads.**
  - LB at 0x13 → rdata=0xFFFFFF88, done in cycle 2, err=0.
  - LBU at 0x13 → 0x00000088.
  - LB at 0x10 → 0xFFFFFFBB.
- **Halfword/word loads.**
  - LH at 0x12 → 0xFFFF8899.
  - LHU at 0x10 → 0x0000AABB.
  - LW at 0x10 → 0x8899AABB.
  - mem_we=0 throughout.
- **Sub-word stores.**
  - SB at 0x11 with wdata=0x12345677 → word 0x10 = 0x889977BB, done in cycle 3, exactly one mem_we cycle, busy high in cycles 1–2.
  - SH at 0x12 with wdata=0x0000CAFE → word 0x10 = 0xCAFEAABB.
- **Word store and back-to-back.**
  - SW at 0x14 with 0xDEADBEEF, then LW at 0x14 issued in the done cycle → rdata=0xDEADBEEF, done 2 cycles later.
  - A req pulsed while busy=1 is ignored.
- **Errors.**
  - LW at 0x11, SH at 0x13, funct3=011, and store with funct3=100 → each gives done=1/err=1 in cycle 2, no mem_we, rdata unchanged.
- **Reset in MERGE.**
  - SB at 0x10 with rst=1 in cycle 2 → mem_we=0, word 0x10 stays 0x8899AABB, cycle 3 has busy=0, done=0, rdata=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Sub-word load/store unit: turns RV32I byte/halfword/word accesses into word-aligned memory
// accesses, using read-modify-write for SB/SH and flagging misaligned or illegal requests.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {StIdle, StAccess, StMerge} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;

  logic        access_err;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    access_err = 1'b0;
    case (funct3_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = addr_q[0];
      3'b010:  access_err = |addr_q[1:0];
      3'b100:  access_err = we_q;
      3'b101:  access_err = we_q | addr_q[0];
      default: access_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_val  = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_val  = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_data = mem_rd;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
      3'b001:  load_data = {{16{half_val[15]}}, half_val};
      3'b100:  load_data = {24'h0, byte_val};
      3'b101:  load_data = {16'h0, half_val};
      default: load_data = mem_rd;
    endcase
  end

  // funct3_q[0] distinguishes SH from SB; only those two ever reach MERGE.
  always_comb begin
    merged = old_q;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    mem_we = 1'b0;
    if (!rst) begin
      mem_we = (state_q == StMerge) ||
               (state_q == StAccess && we_q && !access_err && funct3_q == 3'b010);
    end
    mem_wd = 32'h0;
    if (mem_we) begin
      mem_wd = (state_q == StMerge) ? merged : wdata_q;
    end
    mem_addr = {addr_q[31:2], 2'b00};
    busy     = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      old_q    <= 32'h0;
      rdata    <= 32'h0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          if (access_err) begin
            done    <= 1'b1;
            err     <= 1'b1;
            state_q <= StIdle;
          end else if (!we_q) begin
            rdata   <= load_data;
            done    <= 1'b1;
            state_q <= StIdle;
          end else if (funct3_q == 3'b010) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            old_q   <= mem_rd;
            state_q <= StMerge;
          end
        end
        StMerge: begin
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, err, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [16];

  int tests = 0;
  int fails = 0;

  load_store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:2]] = mem_wd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done; returns latency, mem_we and busy counts.
  task automatic run_op(input logic b2b, input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int wes, output int busys,
                        output logic err_seen);
    if (!b2b) @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    wes = 0; busys = 0;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      wes += int'(mem_we);
      busys += int'(busy);
      @(negedge clk);
      lat++;
    end
    err_seen = err;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int   lat, wes, busys;
    logic e;

    vecs[0]  = '{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 32'h8899AABB};
    vecs[1]  = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2, 0, 32'h8899AABB};
    vecs[2]  = '{1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 32'h8899AABB};
    vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h8899AABB};
    vecs[4]  = '{1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 0, 32'h8899AABB};
    vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 0, 32'h8899AABB};
    // Error cases leave rdata at the last successful load.
    vecs[6]  = '{1'b0, 3'b010, 32'h11, 32'h0, 32'h8899AABB, 1'b1, 2, 0, 32'h8899AABB};
    vecs[7]  = '{1'b1, 3'b001, 32'h13, 32'h1234, 32'h8899AABB, 1'b1, 2, 0, 32'h8899AABB};
    vecs[8]  = '{1'b0, 3'b011, 32'h10, 32'h0, 32'h8899AABB, 1'b1, 2, 0, 32'h8899AABB};
    vecs[9]  = '{1'b1, 3'b100, 32'h10, 32'h55, 32'h8899AABB, 1'b1, 2, 0, 32'h8899AABB};
    vecs[10] = '{1'b1, 3'b000, 32'h11, 32'h12345677, 32'h8899AABB, 1'b0, 3, 1, 32'h889977BB};
    vecs[11] = '{1'b1, 3'b001, 32'h12, 32'h0000CAFE, 32'h8899AABB, 1'b0, 3, 1, 32'hCAFEAABB};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      mem[4] = 32'h8899AABB;
      run_op(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, wes, busys, e);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d mem_we cycles", i), 32'(wes), 32'(vecs[i].exp_wes));
      check($sformatf("vec%0d busy cycles", i), 32'(busys), 32'(vecs[i].exp_lat - 1));
      check($sformatf("vec%0d word 0x10", i), mem[4], vecs[i].exp_word);
      check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].addr & 32'hFFFFFFFC);
    end

    // SW then LW issued in the done cycle.
    run_op(1'b0, 1'b1, 3'b010, 32'h14, 32'hDEADBEEF, lat, wes, busys, e);
    check("sw latency", 32'(lat), 32'd2);
    check("sw mem_we cycles", 32'(wes), 32'd1);
    check("sw word 0x14", mem[5], 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, lat, wes, busys, e);
    check("b2b lw latency", 32'(lat), 32'd2);
    check("b2b lw rdata", rdata, 32'hDEADBEEF);
    check("b2b lw err", 32'(e), 32'h0);

    // A request pulsed while busy must be dropped.
    mem[4] = 32'h8899AABB;
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    check("ignore busy in access", 32'(busy), 32'h1);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h18; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("ignore done", 32'(done), 32'h1);
    check("ignore rdata", rdata, 32'h8899AABB);
    @(negedge clk);
    check("ignore busy after", 32'(busy), 32'h0);
    check("ignore done pulse", 32'(done), 32'h0);
    check("ignore word 0x18", mem[6], 32'h0);

    // Reset while in MERGE.
    mem[4] = 32'h8899AABB;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'hAA;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst merge busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check("rst merge mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rst merge busy after", 32'(busy), 32'h0);
    check("rst merge done", 32'(done), 32'h0);
    check("rst merge err", 32'(err), 32'h0);
    check("rst merge rdata", rdata, 32'h0);
    check("rst merge word 0x10", mem[4], 32'h8899AABB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
